// File: rtl/mt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mt_pkg
//  Description : Shared widths, tag types and zero-register helper for the
//                register-rename map table.
//  Configuration macro: MT_ZERO_REG_EN (AR 31 behaves as a hard-wired zero
//                register that is never renamed).
//  Revision    : 1.0 - initial release
// ============================================================================
package mt_pkg;

    localparam int AR_W      = 5;
    localparam int PR_W      = 7;
    localparam int CDB_WIDTH = 4;
    localparam int NUM_AR    = 32;

    typedef logic [AR_W-1:0] ar_t;
    typedef logic [PR_W-1:0] pr_t;

    localparam ar_t ZERO_AR = ar_t'(NUM_AR - 1);
    localparam pr_t ZERO_PR = pr_t'(NUM_AR - 1);

`ifdef MT_ZERO_REG_EN
    localparam logic ZERO_REG_EN = 1'b1;
`else
    localparam logic ZERO_REG_EN = 1'b0;
`endif

    // True only when the zero register is enabled and the AR is that register.
    function automatic logic is_zero_ar(input ar_t ar);
        return ZERO_REG_EN && (ar == ZERO_AR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mt_src_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : mt_src_lookup
//  Description : Resolves one source operand for the RS: takes the map entry
//                and ready bit already indexed by the source AR, applies the
//                intra-group forward from slot a's new destination, and the
//                same-cycle CDB ready bypass.
//  Ports       : src_ar_i          source AR
//                map_pr_i/rdy_i    current map entry / ready bit of src_ar_i
//                fwd_en_i          an older slot in the group writes fwd_ar_i
//                fwd_ar_i/pr_i     older slot's dest AR and its new PR
//                cdb_broadcast_i   per-lane completion valid
//                cdb_pr_tag_i      per-lane completing PR
//                pr_o / ready_o    resolved PR tag and readiness
//  Configuration macro: MT_ZERO_REG_EN (via mt_pkg::is_zero_ar).
//  Revision    : 1.0 - initial release
// ============================================================================
module mt_src_lookup
    import mt_pkg::*;
(
    input  ar_t                           src_ar_i,
    input  pr_t                           map_pr_i,
    input  logic                          map_rdy_i,
    input  logic                          fwd_en_i,
    input  ar_t                           fwd_ar_i,
    input  pr_t                           fwd_pr_i,
    input  logic [CDB_WIDTH-1:0]          cdb_broadcast_i,
    input  logic [CDB_WIDTH-1:0][PR_W-1:0] cdb_pr_tag_i,
    output pr_t                           pr_o,
    output logic                          ready_o
);

    always_comb begin
        pr_o    = map_pr_i;
        ready_o = map_rdy_i;

        // A tag completing this very cycle is as good as ready.
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (cdb_broadcast_i[l] && (cdb_pr_tag_i[l] == map_pr_i)) begin
                ready_o = 1'b1;
            end
        end

        // A freshly allocated PR from the same group cannot have completed,
        // so the forwarded value is never ready, whatever the CDB shows.
        if (fwd_en_i && (src_ar_i == fwd_ar_i) && !is_zero_ar(src_ar_i)) begin
            pr_o    = fwd_pr_i;
            ready_o = 1'b0;
        end

        if (is_zero_ar(src_ar_i)) begin
            pr_o    = ZERO_PR;
            ready_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/map_table.sv
`default_nettype none
// ============================================================================
//  Module      : map_table
//  Description : Register-rename map table for a 2-wide out-of-order core.
//                Holds AR->PR mapping plus a ready bit per AR. Outputs are
//                combinational from current state; updates land next cycle.
//  Ports       : clock_i, reset_i            clock, synchronous active-high reset
//                rob_dispatch_num_i          0/1/2 instrs dispatched (3 == 2)
//                fl_pr0_i / fl_pr1_i         new PRs for slot a / slot b dests
//                rob_ar_a/_b_i (+_valid_i)   dest ARs of slot a / b
//                rob_ar_a1/a2/b1/b2_i (+_valid_i) source ARs
//                cdb_broadcast_i, cdb_pr_tag0..3_i, cdb_ar_tag0..3_i  CDB lanes
//                rob_p0told_o / rob_p1told_o previous mappings of dest ARs
//                rs_pr_a1/a2/b1/b2_o (+_ready_o) source PR tags and readiness
//  Configuration macro: MT_ZERO_REG_EN (AR 31 is the zero register).
//  Revision    : 1.0 - initial release
// ============================================================================
module map_table
    import mt_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           rob_dispatch_num_i,
    input  pr_t                  fl_pr0_i,
    input  pr_t                  fl_pr1_i,
    input  ar_t                  rob_ar_a_i,
    input  logic                 rob_ar_a_valid_i,
    input  ar_t                  rob_ar_b_i,
    input  logic                 rob_ar_b_valid_i,
    input  ar_t                  rob_ar_a1_i,
    input  logic                 rob_ar_a1_valid_i,
    input  ar_t                  rob_ar_a2_i,
    input  logic                 rob_ar_a2_valid_i,
    input  ar_t                  rob_ar_b1_i,
    input  logic                 rob_ar_b1_valid_i,
    input  ar_t                  rob_ar_b2_i,
    input  logic                 rob_ar_b2_valid_i,
    input  logic [CDB_WIDTH-1:0] cdb_broadcast_i,
    input  pr_t                  cdb_pr_tag0_i,
    input  pr_t                  cdb_pr_tag1_i,
    input  pr_t                  cdb_pr_tag2_i,
    input  pr_t                  cdb_pr_tag3_i,
    input  ar_t                  cdb_ar_tag0_i,
    input  ar_t                  cdb_ar_tag1_i,
    input  ar_t                  cdb_ar_tag2_i,
    input  ar_t                  cdb_ar_tag3_i,
    output pr_t                  rob_p0told_o,
    output pr_t                  rob_p1told_o,
    output pr_t                  rs_pr_a1_o,
    output pr_t                  rs_pr_a2_o,
    output pr_t                  rs_pr_b1_o,
    output pr_t                  rs_pr_b2_o,
    output logic                 rs_pr_a1_ready_o,
    output logic                 rs_pr_a2_ready_o,
    output logic                 rs_pr_b1_ready_o,
    output logic                 rs_pr_b2_ready_o
);

    localparam int NUM_SRC = 4;

    pr_t               map_q [NUM_AR];
    pr_t               map_d [NUM_AR];
    logic [NUM_AR-1:0] rdy_q;
    logic [NUM_AR-1:0] rdy_d;

    logic              w_wr_a;
    logic              w_wr_b;
    pr_t               w_cdb_pr [CDB_WIDTH];
    ar_t               w_cdb_ar [CDB_WIDTH];
    logic [CDB_WIDTH-1:0][PR_W-1:0] w_cdb_pr_pk;

    ar_t               w_src_ar  [NUM_SRC];
    pr_t               w_src_pr  [NUM_SRC];
    logic              w_src_rdy [NUM_SRC];

    // Source valids only qualify don't-care outputs; nothing depends on them.
    logic              w_unused_src_valid;
    assign w_unused_src_valid = ^{rob_ar_a1_valid_i, rob_ar_a2_valid_i,
                                  rob_ar_b1_valid_i, rob_ar_b2_valid_i};

    assign w_cdb_pr[0] = cdb_pr_tag0_i;
    assign w_cdb_pr[1] = cdb_pr_tag1_i;
    assign w_cdb_pr[2] = cdb_pr_tag2_i;
    assign w_cdb_pr[3] = cdb_pr_tag3_i;
    assign w_cdb_ar[0] = cdb_ar_tag0_i;
    assign w_cdb_ar[1] = cdb_ar_tag1_i;
    assign w_cdb_ar[2] = cdb_ar_tag2_i;
    assign w_cdb_ar[3] = cdb_ar_tag3_i;
    assign w_cdb_pr_pk = {cdb_pr_tag3_i, cdb_pr_tag2_i, cdb_pr_tag1_i, cdb_pr_tag0_i};

    // dispatch_num==3 decodes like 2 because bit 1 alone selects slot b.
    assign w_wr_a = (rob_dispatch_num_i != 2'd0) && rob_ar_a_valid_i && !is_zero_ar(rob_ar_a_i);
    assign w_wr_b = rob_dispatch_num_i[1] && rob_ar_b_valid_i && !is_zero_ar(rob_ar_b_i);

    // ------------------------------------------------------------------
    // Told: slot b sees slot a's new mapping when both name the same AR.
    // ------------------------------------------------------------------
    always_comb begin
        rob_p0told_o = is_zero_ar(rob_ar_a_i) ? ZERO_PR : map_q[rob_ar_a_i];
        if (is_zero_ar(rob_ar_b_i)) begin
            rob_p1told_o = ZERO_PR;
        end else if (w_wr_a && (rob_ar_b_i == rob_ar_a_i)) begin
            rob_p1told_o = fl_pr0_i;
        end else begin
            rob_p1told_o = map_q[rob_ar_b_i];
        end
    end

    // ------------------------------------------------------------------
    // Source lookups: index 0/1 are slot a, 2/3 are slot b.
    // ------------------------------------------------------------------
    assign w_src_ar[0] = rob_ar_a1_i;
    assign w_src_ar[1] = rob_ar_a2_i;
    assign w_src_ar[2] = rob_ar_b1_i;
    assign w_src_ar[3] = rob_ar_b2_i;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        mt_src_lookup u_lookup (
            .src_ar_i        (w_src_ar[s]),
            .map_pr_i        (map_q[w_src_ar[s]]),
            .map_rdy_i       (rdy_q[w_src_ar[s]]),
            .fwd_en_i        ((s >= 2) ? w_wr_a : 1'b0),
            .fwd_ar_i        (rob_ar_a_i),
            .fwd_pr_i        (fl_pr0_i),
            .cdb_broadcast_i (cdb_broadcast_i),
            .cdb_pr_tag_i    (w_cdb_pr_pk),
            .pr_o            (w_src_pr[s]),
            .ready_o         (w_src_rdy[s])
        );
    end

    assign rs_pr_a1_o       = w_src_pr[0];
    assign rs_pr_a2_o       = w_src_pr[1];
    assign rs_pr_b1_o       = w_src_pr[2];
    assign rs_pr_b2_o       = w_src_pr[3];
    assign rs_pr_a1_ready_o = w_src_rdy[0];
    assign rs_pr_a2_ready_o = w_src_rdy[1];
    assign rs_pr_b1_ready_o = w_src_rdy[2];
    assign rs_pr_b2_ready_o = w_src_rdy[3];

    // ------------------------------------------------------------------
    // Next state: CDB first, then dispatch writes so dispatch wins on a
    // shared AR, and slot b last so it wins over slot a.
    // ------------------------------------------------------------------
    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q;

        // Only a tag still mapped to its AR marks it ready; stale tags drop.
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (cdb_broadcast_i[l] && (map_q[w_cdb_ar[l]] == w_cdb_pr[l])) begin
                rdy_d[w_cdb_ar[l]] = 1'b1;
            end
        end

        if (w_wr_a) begin
            map_d[rob_ar_a_i] = fl_pr0_i;
            rdy_d[rob_ar_a_i] = 1'b0;
        end
        if (w_wr_b) begin
            map_d[rob_ar_b_i] = fl_pr1_i;
            rdy_d[rob_ar_b_i] = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_AR; i++) begin
                map_q[i] <= pr_t'(i);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_map_table
//  Description : Directed self-checking bench for map_table. Inputs change
//                just after the falling edge; outputs are checked 1 ns later.
//  Configuration macro: MT_ZERO_REG_EN selects the zero-register AR31 step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_map_table;
    import mt_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [1:0]           num;
    pr_t                  fl0, fl1;
    ar_t                  ar_a, ar_b, a1, a2, b1, b2;
    logic                 ar_a_v, ar_b_v, a1_v, a2_v, b1_v, b2_v;
    logic [CDB_WIDTH-1:0] bc;
    pr_t                  cpr0, cpr1, cpr2, cpr3;
    ar_t                  car0, car1, car2, car3;
    pr_t                  p0told, p1told, pa1, pa2, pb1, pb2;
    logic                 ra1, ra2, rb1, rb2;

    int n_cmp;
    int n_err;

    map_table dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .rob_dispatch_num_i(num),
        .fl_pr0_i          (fl0),
        .fl_pr1_i          (fl1),
        .rob_ar_a_i        (ar_a),
        .rob_ar_a_valid_i  (ar_a_v),
        .rob_ar_b_i        (ar_b),
        .rob_ar_b_valid_i  (ar_b_v),
        .rob_ar_a1_i       (a1),
        .rob_ar_a1_valid_i (a1_v),
        .rob_ar_a2_i       (a2),
        .rob_ar_a2_valid_i (a2_v),
        .rob_ar_b1_i       (b1),
        .rob_ar_b1_valid_i (b1_v),
        .rob_ar_b2_i       (b2),
        .rob_ar_b2_valid_i (b2_v),
        .cdb_broadcast_i   (bc),
        .cdb_pr_tag0_i     (cpr0),
        .cdb_pr_tag1_i     (cpr1),
        .cdb_pr_tag2_i     (cpr2),
        .cdb_pr_tag3_i     (cpr3),
        .cdb_ar_tag0_i     (car0),
        .cdb_ar_tag1_i     (car1),
        .cdb_ar_tag2_i     (car2),
        .cdb_ar_tag3_i     (car3),
        .rob_p0told_o      (p0told),
        .rob_p1told_o      (p1told),
        .rs_pr_a1_o        (pa1),
        .rs_pr_a2_o        (pa2),
        .rs_pr_b1_o        (pb1),
        .rs_pr_b2_o        (pb2),
        .rs_pr_a1_ready_o  (ra1),
        .rs_pr_a2_ready_o  (ra2),
        .rs_pr_b1_ready_o  (rb1),
        .rs_pr_b2_ready_o  (rb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        num = 2'd0; fl0 = '0; fl1 = '0;
        ar_a = '0; ar_b = '0; ar_a_v = 1'b0; ar_b_v = 1'b0;
        a1 = '0; a2 = '0; b1 = '0; b2 = '0;
        a1_v = 1'b1; a2_v = 1'b1; b1_v = 1'b1; b2_v = 1'b1;
        bc = '0;
        cpr0 = '0; cpr1 = '0; cpr2 = '0; cpr3 = '0;
        car0 = '0; car1 = '0; car2 = '0; car3 = '0;
    endtask

    // Let the current inputs be clocked in, then return just after the fall.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state: identity mapping, everything ready.
        a1 = 5'd5; a2 = 5'd6; b1 = 5'd7; b2 = 5'd8; ar_a = 5'd2; ar_b = 5'd9;
        #1;
        chk("rst_a1", pa1, 5);  chk("rst_a1_rdy", ra1, 1);
        chk("rst_b2", pb2, 8);  chk("rst_b2_rdy", rb2, 1);
        chk("rst_p1told", p1told, 9);

        // Step 1: dispatch_num=0 with valid dest never writes.
        ar_a = 5'd2; ar_a_v = 1'b1; fl0 = 7'd5;
        #1 chk("nodisp_told_c0", p0told, 2);
        @(posedge clk); @(negedge clk);
        #1 chk("nodisp_told_c1", p0told, 2);
        tick();
        a1 = 5'd2;
        #1 chk("nodisp_map2", pa1, 2);

        // Step 2: two-wide dispatch, a=3 b=4.
        num = 2'd2; ar_a = 5'd3; ar_a_v = 1'b1; ar_b = 5'd4; ar_b_v = 1'b1;
        fl0 = 7'd32; fl1 = 7'd33;
        a1 = 5'd5; a2 = 5'd6; b1 = 5'd7; b2 = 5'd8;
        #1;
        chk("d2_p0told", p0told, 3); chk("d2_p1told", p1told, 4);
        chk("d2_a2", pa2, 6); chk("d2_b1", pb1, 7);
        chk("d2_b1_rdy", rb1, 1);
        tick();

        // Step 3: new mappings visible, not ready; slot b without forwarding.
        num = 2'd1; ar_a = 5'd5; ar_a_v = 1'b1; fl0 = 7'd34;
        a1 = 5'd3; a2 = 5'd4; b1 = 5'd3;
        #1;
        chk("d1_p0told", p0told, 5);
        chk("d1_a1", pa1, 32); chk("d1_a1_rdy", ra1, 0);
        chk("d1_a2", pa2, 33); chk("d1_a2_rdy", ra2, 0);
        chk("d1_b1", pb1, 32);
        tick();

        // Step 4: CDB hit on AR3 (bypass), stale tags on AR4 and AR3.
        a1 = 5'd3; a2 = 5'd4;
        bc = 4'b0111;
        cpr0 = 7'd32; car0 = 5'd3;
        cpr1 = 7'd4;  car1 = 5'd4;
        cpr2 = 7'd5;  car2 = 5'd3;
        #1;
        chk("cdb_bypass_rdy", ra1, 1);
        chk("cdb_other_rdy", ra2, 0);
        tick();
        a1 = 5'd3; a2 = 5'd4; b1 = 5'd5;
        #1;
        chk("cdb_state_rdy", ra1, 1);
        chk("cdb_stale_rdy", ra2, 0);
        chk("map5", pb1, 34); chk("map5_rdy", rb1, 0);

        // Step 4b: dispatch and CDB hit on the same AR -> dispatch wins.
        num = 2'd1; ar_a = 5'd5; ar_a_v = 1'b1; fl0 = 7'd50;
        bc = 4'b1000; cpr3 = 7'd34; car3 = 5'd5;
        #1 chk("race_p0told", p0told, 34);
        tick();
        a1 = 5'd5;
        #1;
        chk("race_map", pa1, 50); chk("race_rdy", ra1, 0);

        // Step 5: a=b=7, slot b source forwarded, CDB carrying 40 ignored.
        num = 2'd2; ar_a = 5'd7; ar_b = 5'd7; ar_a_v = 1'b1; ar_b_v = 1'b1;
        fl0 = 7'd40; fl1 = 7'd41; a1 = 5'd7; b1 = 5'd7; b2 = 5'd9;
        bc = 4'b0001; cpr0 = 7'd40; car0 = 5'd7;
        #1;
        chk("same_p0told", p0told, 7);
        chk("same_p1told", p1told, 40);
        chk("same_a1", pa1, 7); chk("same_a1_rdy", ra1, 1);
        chk("fwd_b1", pb1, 40); chk("fwd_b1_rdy", rb1, 0);
        chk("nofwd_b2", pb2, 9);
        tick();
        a1 = 5'd7;
        #1;
        chk("bwins_map7", pa1, 41); chk("bwins_rdy7", ra1, 0);

        // dispatch_num=3 behaves as 2.
        num = 2'd3; ar_a = 5'd10; ar_b = 5'd11; ar_a_v = 1'b1; ar_b_v = 1'b1;
        fl0 = 7'd60; fl1 = 7'd61;
        tick();
        a1 = 5'd10; a2 = 5'd11;
        #1;
        chk("d3_map10", pa1, 60); chk("d3_map11", pa2, 61);

        // dispatch_num=1 ignores a valid slot b; invalid slot a is not written.
        num = 2'd1; ar_a = 5'd12; ar_a_v = 1'b1; fl0 = 7'd70;
        ar_b = 5'd13; ar_b_v = 1'b1; fl1 = 7'd71;
        tick();
        a1 = 5'd13; a2 = 5'd12;
        #1;
        chk("d1_map13", pa1, 13); chk("d1_map13_rdy", ra1, 1);
        chk("d1_map12", pa2, 70);
        num = 2'd1; ar_a = 5'd14; ar_a_v = 1'b0; fl0 = 7'd72;
        tick();
        a1 = 5'd14;
        #1 chk("inv_map14", pa1, 14);

        // AR31 handling.
        num = 2'd1; ar_a = 5'd31; ar_a_v = 1'b1; fl0 = 7'd90;
        #1 chk("ar31_p0told", p0told, 31);
        tick();
        a1 = 5'd31; ar_b = 5'd31;
        #1;
`ifdef MT_ZERO_REG_EN
        chk("zr_src31", pa1, 31); chk("zr_src31_rdy", ra1, 1);
        chk("zr_told31", p1told, 31);
`else
        chk("ar31_src", pa1, 90); chk("ar31_src_rdy", ra1, 0);
        chk("ar31_told", p1told, 90);
`endif

        // Reset overrides a concurrent dispatch.
        rst = 1'b1; num = 2'd1; ar_a = 5'd20; ar_a_v = 1'b1; fl0 = 7'd99;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; idle();
        a1 = 5'd20; a2 = 5'd3;
        #1;
        chk("rst2_map20", pa1, 20); chk("rst2_map3", pa2, 3);
        chk("rst2_rdy3", ra2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
